mem_stage: RTL
==============

# mem_stage

Memory-access stage of the MUSA pipeline, directly downstream of the EX stage. It consumes the ALU result as an effective address (or as a pass-through value), performs word loads and stores to an external data memory over a req/ack handshake, and registers the outcome toward write-back. It stalls upstream while an access is outstanding and reports misaligned and timed-out accesses.

## Interface
- TIMEOUT, 16: maximum cycles `mem_req` stays high without `mem_ack` before a bus error is declared (≥2).
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  EX presents an instruction this cycle.
- in_result  in  32  ALU result: effective address for load/store, write-back value otherwise.
- in_store_data  in  32  store data (rt).
- in_mem_read  in  1  load word.
- in_mem_write  in  1  store word.
- in_reg_write  in  1  instruction writes the register file.
- in_write_reg  in  5  destination register.
- stall  out  1  stage busy; EX must hold all `in_*` stable.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store, 0 = load; valid while `mem_req`.
- mem_addr  out  32  word-aligned byte address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  load data, sampled when `mem_ack` is high.
- mem_ack  in  1  one-cycle completion pulse.
- wb_valid  out  1  write-back bundle valid, one-cycle pulse per instruction.
- wb_reg_write  out  1  commit to register file.
- wb_write_reg  out  5  destination register.
- wb_data  out  32  loaded word or pass-through result.
- misaligned  out  1  pulse alongside `wb_valid`: load/store with `in_result[1:0] != 0`.
- bus_error  out  1  pulse alongside `wb_valid`: access timed out.

## Operation
- FSM states: IDLE, ACCESS.
- IDLE with `in_valid`:
  - Neither read nor write: next cycle `wb_valid=1`, `wb_data=in_result`, `wb_reg_write=in_reg_write`. Remain in IDLE.
  - Load or store, aligned: latch address, data, `we`, and destination. Go to ACCESS.
  - Load or store, misaligned: no memory request. Next cycle `wb_valid=1`, `misaligned=1`, `wb_reg_write=0`.
  - `in_mem_read` and `in_mem_write` both high: treated as a store.
- ACCESS:
  - `mem_req=1`; `mem_we`, `mem_addr`, `mem_wdata` are constant from the latches; `stall=1`.
  - On `mem_ack`: go to IDLE. Next cycle `wb_valid=1`; `wb_data` = `mem_rdata` for a load or the address for a store; `wb_reg_write` = latched reg_write for a load, 0 for a store.
  - Wait counter starts at 0 on entry and increments each ACCESS cycle without ack.
  - If the counter reaches TIMEOUT−1 with no ack: go to IDLE. Next cycle `wb_valid=1`, `bus_error=1`, `wb_reg_write=0`.
  - Ack in the same cycle as the timeout condition wins; no error.
- `mem_ack` while `mem_req=0` is ignored.
- A write to register 0 is passed through unchanged; write-back discards it.

## Timing
- Reset values: state=IDLE, counter=0; `stall`, `mem_req`, `mem_we`, `wb_valid`, `wb_reg_write`, `misaligned`, `bus_error` = 0; `mem_addr`, `mem_wdata`, `wb_data` = 0; `wb_write_reg` = 0.
- All outputs are registered except `stall`, which is decoded from state (high iff state=ACCESS).
- Latencies:
  - Non-memory or misaligned instruction: 1 cycle, accepted back-to-back every cycle.
  - Memory access: `mem_req` rises the cycle after acceptance. With ack k cycles after `mem_req` rises (k ≥ 0), `wb_valid` follows 1 cycle after ack.
- No instruction is accepted while `stall=1`.
- The first instruction after return to IDLE is accepted in the same cycle that `wb_valid` of the previous one is high.
- `wb_*` fields hold their last value when `wb_valid=0`.
- Reset mid-ACCESS: `mem_req` drops the next cycle, the in-flight access is abandoned with no `wb_valid`, and a late ack is ignored.

## Structure
- Shared package (`musa_pkg`): mem state enum, `WORD_BYTES=4`, alignment mask constant.
- Timeout counter width is `$clog2(TIMEOUT)`.
- One natural sub-module: `mem_wait_counter` (clear/enable/terminal-count), reusable for instruction-fetch timeouts.

## Test plan
- ALU op: `in_result=32'h0000_0042`, `reg_write=1`, `write_reg=5` -> next cycle `wb_valid=1`, `wb_data=42h`, `wb_write_reg=5`, `stall` never high.
- Load from `32'h100`, ack 3 cycles after `mem_req` rises, `mem_rdata=32'hDEAD_BEEF` -> `stall` high 4 cycles, `mem_we=0`, `wb_data=DEADBEEFh`, `wb_reg_write=1`.
- Store `32'h1234_5678` to `32'h200`, zero-wait ack -> `mem_we=1`, `mem_wdata` correct for one `mem_req` cycle, `wb_reg_write=0`.
- Load from `32'h102` -> `mem_req` never asserted; `misaligned=1` with `wb_valid`; `wb_reg_write=0`.
- Load with no ack, TIMEOUT=16 -> `mem_req` high exactly 16 cycles, then `bus_error=1`; a second case with ack on the 16th cycle -> no error.
- Reset asserted 2 cycles into ACCESS, then ack pulsed -> `mem_req=0` the next cycle, no `wb_valid`, all outputs at reset values.

Source files
------------

// File: rtl/musa_pkg.sv
// Shared MUSA pipeline definitions: memory-stage state encoding, word geometry
// and the alignment check used when accepting loads and stores.
package musa_pkg;

    typedef enum logic [0:0] {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [31:0] ALIGN_MASK = 32'(WORD_BYTES - 1);

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr & ALIGN_MASK) != 32'd0;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the external memory (slave).
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ack);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_stage_wait_counter.sv
// Wait counter with clear/enable; terminal flags LIMIT-1 cycles counted.
// Shared between the data-memory stage and instruction-fetch timeouts.
module mem_wait_counter #(
    parameter int unsigned LIMIT = 16,
    parameter int unsigned CNT_W = $clog2(LIMIT)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear dominates enable.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/mem_stage.sv
// MUSA memory-access stage: word loads/stores over a req/ack bus, pass-through of
// ALU results, misalignment and timeout reporting toward write-back.
module mem_stage
    import musa_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_result,
    input  logic [31:0] in_store_data,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic        in_reg_write,
    input  logic [4:0]  in_write_reg,
    output logic        stall,
    mem_stage_if.master mem,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_write_reg,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic        bus_error
);
    mem_state_e  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        lat_reg_write_q, lat_reg_write_d;
    logic [4:0]  lat_write_reg_q, lat_write_reg_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic [4:0]  wb_write_reg_q, wb_write_reg_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_error_q, bus_error_d;

    logic mem_op_s;
    logic mis_s;
    logic timeout_s;
    logic in_access_s;

    assign mem_op_s    = in_mem_read | in_mem_write;
    assign mis_s       = is_misaligned(in_result);
    assign in_access_s = (state_q == MEM_ACCESS);

    mem_wait_counter #(.LIMIT(TIMEOUT)) u_wait (
        .clock    (clock),
        .reset    (reset),
        .clear    (!in_access_s),
        .enable   (in_access_s && !mem.mem_ack),
        .terminal (timeout_s)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: ack beats the timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE: begin
                if (in_valid && mem_op_s && !mis_s) begin
                    state_d = MEM_ACCESS;
                end else begin
                    state_d = MEM_IDLE;
                end
            end
            MEM_ACCESS: begin
                if (mem.mem_ack || timeout_s) begin
                    state_d = MEM_IDLE;
                end else begin
                    state_d = MEM_ACCESS;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    // Output/latch next values; wb_* fields hold unless a result retires.
    always_comb begin
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        lat_reg_write_d = lat_reg_write_q;
        lat_write_reg_d = lat_write_reg_q;
        wb_valid_d      = 1'b0;
        wb_reg_write_d  = wb_reg_write_q;
        wb_write_reg_d  = wb_write_reg_q;
        wb_data_d       = wb_data_q;
        misaligned_d    = 1'b0;
        bus_error_d     = 1'b0;
        mem_req_d       = (state_d == MEM_ACCESS);
        case (state_q)
            MEM_IDLE: begin
                if (in_valid && (!mem_op_s || mis_s)) begin
                    wb_valid_d     = 1'b1;
                    misaligned_d   = mem_op_s;
                    wb_reg_write_d = in_reg_write && !mem_op_s;
                    wb_write_reg_d = in_write_reg;
                    wb_data_d      = in_result;
                end else if (in_valid) begin
                    mem_we_d        = in_mem_write;
                    mem_addr_d      = in_result;
                    mem_wdata_d     = in_store_data;
                    lat_reg_write_d = in_reg_write;
                    lat_write_reg_d = in_write_reg;
                end else begin
                    wb_valid_d = 1'b0;
                end
            end
            MEM_ACCESS: begin
                if (mem.mem_ack) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = lat_reg_write_q && !mem_we_q;
                    wb_write_reg_d = lat_write_reg_q;
                    wb_data_d      = mem_we_q ? mem_addr_q : mem.mem_rdata;
                end else if (timeout_s) begin
                    wb_valid_d     = 1'b1;
                    bus_error_d    = 1'b1;
                    wb_reg_write_d = 1'b0;
                    wb_write_reg_d = lat_write_reg_q;
                end else begin
                    wb_valid_d = 1'b0;
                end
            end
            default: wb_valid_d = 1'b0;
        endcase
    end

    // Output and latch registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= 32'd0;
            mem_wdata_q     <= 32'd0;
            lat_reg_write_q <= 1'b0;
            lat_write_reg_q <= 5'd0;
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_write_reg_q  <= 5'd0;
            wb_data_q       <= 32'd0;
            misaligned_q    <= 1'b0;
            bus_error_q     <= 1'b0;
        end else begin
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            lat_reg_write_q <= lat_reg_write_d;
            lat_write_reg_q <= lat_write_reg_d;
            wb_valid_q      <= wb_valid_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_write_reg_q  <= wb_write_reg_d;
            wb_data_q       <= wb_data_d;
            misaligned_q    <= misaligned_d;
            bus_error_q     <= bus_error_d;
        end
    end

    assign stall         = in_access_s;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_write_reg  = wb_write_reg_q;
    assign wb_data       = wb_data_q;
    assign misaligned    = misaligned_q;
    assign bus_error     = bus_error_q;
endmodule
